// File: rtl/alu_op_sequencer_if.sv
// ID-to-EX handshake bundle for the ALU-op sequencer.
// master = instruction source / EX consumer, slave = sequencer.
interface alu_op_sequencer_if #(
   parameter int ALU_OP_W = 5,
   parameter int CNT_W    = 32
);
   logic                flush;
   logic                id_valid;
   logic                id_ready;
   logic [6:0]          opcode;
   logic [2:0]          func3;
   logic [6:0]          func7;
   logic [ALU_OP_W-1:0] alu_op;
   logic                ex_valid;
   logic                illegal;
   logic                busy;
   logic [CNT_W-1:0]    stall_cnt;

   modport master (
      output flush, id_valid, opcode, func3, func7,
      input  id_ready, alu_op, ex_valid, illegal, busy, stall_cnt
   );

   modport slave (
      input  flush, id_valid, opcode, func3, func7,
      output id_ready, alu_op, ex_valid, illegal, busy, stall_cnt
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// RV32IM ALU-op decoder with registered op code, multi-cycle MUL/DIV sequencing
// and a saturating busy-cycle counter.
module alu_op_sequencer #(
   parameter int ALU_OP_W   = 5,
   parameter int ENABLE_M   = 1,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                reset,
   alu_op_sequencer_if.slave   bus
);
   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state, state_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic [ALU_OP_W-1:0] op_q, op_nx;
   logic                ill_q, ill_nx;
   logic                exv_q, exv_nx;
   logic [CNT_W-1:0]    stall_q;

   logic [4:0]          dec_op;
   logic                dec_ill;
   logic [CW-1:0]       dec_lat;
   logic                accept;

   // Register-register base ops indexed by func3 (also OP_IMM except shifts)
   function automatic logic [4:0] base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_op = 5'd0;   // ADD
         3'b001:  base_op = 5'd5;   // SLL
         3'b010:  base_op = 5'd8;   // SLT
         3'b011:  base_op = 5'd9;   // SLTU
         3'b100:  base_op = 5'd4;   // XOR
         3'b101:  base_op = 5'd6;   // SRL
         3'b110:  base_op = 5'd3;   // OR
         default: base_op = 5'd2;   // AND
      endcase
   endfunction

   always_comb begin
      dec_op  = 5'd0;
      dec_ill = 1'b0;
      dec_lat = CW'(1);
      case (bus.opcode)
         OPC_LOAD:
            dec_ill = !(bus.func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
         OPC_STORE:
            dec_ill = !(bus.func3 inside {3'b000, 3'b001, 3'b010});
         OPC_JALR:
            dec_ill = (bus.func3 != 3'b000);
         OPC_LUI, OPC_AUIPC: ;
         OPC_BRANCH:
            case (bus.func3)
               3'b000:  dec_op = 5'd10;
               3'b001:  dec_op = 5'd11;
               3'b100:  dec_op = 5'd12;
               3'b101:  dec_op = 5'd13;
               3'b110:  dec_op = 5'd14;
               3'b111:  dec_op = 5'd15;
               default: dec_ill = 1'b1;
            endcase
         OPC_OP:
            if (bus.func7 == F7_BASE) begin
               dec_op = base_op(bus.func3);
            end else if (bus.func7 == F7_ALT && bus.func3 == 3'b000) begin
               dec_op = 5'd1;
            end else if (bus.func7 == F7_ALT && bus.func3 == 3'b101) begin
               dec_op = 5'd7;
            end else if (bus.func7 == F7_MEXT && ENABLE_M != 0) begin
               dec_op  = {2'b10, bus.func3};
               dec_lat = bus.func3[2] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else begin
               dec_ill = 1'b1;
            end
         OPC_OPIMM:
            // Only the shift encodings look at func7; ADDI never becomes SUB
            if (bus.func3 == 3'b001) begin
               dec_op  = 5'd5;
               dec_ill = (bus.func7 != F7_BASE);
            end else if (bus.func3 == 3'b101) begin
               dec_op  = (bus.func7 == F7_ALT) ? 5'd7 : 5'd6;
               dec_ill = (bus.func7 != F7_BASE) && (bus.func7 != F7_ALT);
            end else begin
               dec_op = base_op(bus.func3);
            end
         default:
            dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_op  = 5'd0;
         dec_lat = CW'(1);
      end
   end

   assign accept = bus.id_valid && (state == IDLE) && !bus.flush;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      op_nx    = op_q;
      ill_nx   = ill_q;
      exv_nx   = 1'b0;
      case (state)
         IDLE:
            if (accept) begin
               op_nx  = ALU_OP_W'(dec_op);
               ill_nx = dec_ill;
               cnt_nx = dec_lat - CW'(1);
               if (dec_lat == CW'(1)) exv_nx = 1'b1;
               else                   state_nx = BUSY;
            end
         BUSY:
            if (bus.flush) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CW'(1)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               exv_nx   = 1'b1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         ill_q <= 1'b0;
         exv_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         op_q  <= op_nx;
         ill_q <= ill_nx;
         exv_q <= exv_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 stall_q <= '0;
      else if (state == BUSY && stall_q != '1)   stall_q <= stall_q + CNT_W'(1);
   end

   assign bus.id_ready  = (state == IDLE);
   assign bus.busy      = (state == BUSY);
   assign bus.alu_op    = op_q;
   assign bus.illegal   = ill_q;
   assign bus.ex_valid  = exv_q;
   assign bus.stall_cnt = stall_q;
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered ALU-operation decoder with multi-cycle sequencing for the RV32IM execute stage. Sits between ID and EX: accepts opcode/func3/func7 with a valid/ready handshake, decodes RV32I arithmetic, branch, load/store and jump operations plus optional M-extension operations into an ALU op code, and holds that code. For MUL-class and DIV-class ops it counts a configurable latency and back-pressures ID until the result is final. Also provides a saturating stall-cycle counter for performance measurement.

## Interface
- ALU_OP_W, 5: width of alu_op; must be ≥5.
- ENABLE_M, 1: 1 decodes M-extension; 0 flags M ops illegal.
- MUL_CYCLES, 3: total latency of MUL/MULH/MULHSU/MULHU (≥1).
- DIV_CYCLES, 33: total latency of DIV/DIVU/REM/REMU (≥1).
- CNT_W, 32: width of stall_cnt.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous kill of held/in-flight op.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  sequencer can accept; = (state==IDLE).
- opcode  in  7  instruction[6:0].
- func3  in  3  instruction[14:12].
- func7  in  7  instruction[31:25].
- alu_op  out  ALU_OP_W  registered op code.
- ex_valid  out  1  alu_op/result final this cycle (one-cycle pulse).
- illegal  out  1  registered; qualifies ex_valid for undecodable ops.
- busy  out  1  multi-cycle op in progress.
- stall_cnt  out  CNT_W  saturating count of busy cycles.

## Operation
- Op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14, BGEU 15, MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- LOAD (0000011) func3 ∈ {000,001,010,100,101}, STORE (0100011) func3 ∈ {000,001,010}, JALR (1100111) func3=000, LUI (0110111), AUIPC (0010111) → ADD.
- BRANCH (1100011): func3 000/001/100/101/110/111 → BEQ/BNE/BLT/BGE/BLTU/BGEU; 010/011 illegal.
- OP (0110011): func7=0000000 → ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by func3; func7=0100000 legal only with func3 000 (SUB) or 101 (SRA); func7=0000001 → M op by func3 (000..111 = MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU) when ENABLE_M=1.
- OP_IMM (0010011): func7 ignored except func3=001 (needs 0000000 → SLL) and 101 (0000000 → SRL, 0100000 → SRA); ADDI never decodes as SUB.
- Anything else: alu_op=0, illegal=1, treated as single-cycle.
- States: IDLE, BUSY. Accept = id_valid & id_ready & !flush.
- Accept, latency L (1 for non-M, MUL_CYCLES or DIV_CYCLES for M): register alu_op, illegal; if L=1 stay IDLE and pulse ex_valid; else go BUSY with cnt=L-1.
- BUSY: cnt decrements each cycle; at cnt=1 → IDLE and ex_valid pulses next cycle; alu_op held constant throughout.
- flush: BUSY → IDLE, cnt=0, ex_valid=0 next cycle; flush overrides a simultaneous accept; alu_op keeps last value.
- stall_cnt increments each cycle busy=1, saturates at all-ones, cleared only by reset.

## Timing
- Reset values: alu_op=0, ex_valid=0, illegal=0, busy=0, id_ready=1, stall_cnt=0, state IDLE.
- Single-cycle op accepted at edge N: alu_op, ex_valid=1 during cycle N..N+1; id_ready stays 1 (back-to-back accept every cycle).
- Latency-L op accepted at edge N: busy=1, id_ready=0 for cycles N+1..N+L-1; ex_valid=1 in cycle N+L-1..N+L (i.e. after L-1 busy cycles); id_ready=1 in that same cycle, so next op may be accepted at edge N+L.
- ex_valid never high while busy=1.
- Internal counter width = $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- reset asserted mid-BUSY: all outputs to reset values immediately, no ex_valid pulse.

## Test plan
- OP, func3=000, func7=0000000 then func7=0100000 on consecutive cycles → alu_op 0 then 1, ex_valid high two consecutive cycles, id_ready constantly 1.
- OP_IMM func3=101 func7=0100000 → alu_op 7; OP_IMM func3=000 func7=0100000 → alu_op 0; BRANCH func3=110 → 14; BRANCH func3=010 → alu_op 0, illegal 1.
- DIV (func7=0000001, func3=100), DIV_CYCLES=33 → alu_op 20, busy/id_ready=0 for 32 cycles, single ex_valid on 33rd, stall_cnt=32.
- MUL with MUL_CYCLES=3 followed immediately by ADD held on id_valid → ADD accepted exactly at the edge after MUL's ex_valid cycle; stall_cnt +2.
- flush in busy cycle 10 of DIV → IDLE next cycle, no ex_valid, id_ready=1; flush together with id_valid in IDLE → no accept.
- ENABLE_M=0, MUL → illegal=1, ex_valid next cycle, busy never set; reset pulse during DIV busy → all outputs zero asynchronously, stall_cnt=0.
